// File: rtl/sys_bridge_hs.sv
// sys_bridge_hs: handshaked CPU-to-device bridge for the system-bus region.
//
// Latches one CPU access, decodes the target device from the address, drives
// that device until it answers (or the wait budget runs out), then returns the
// registered read data with a one-cycle PrReady pulse.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   PrReq/PrWen       CPU request and direction (1 = write), held until PrReady
//   PrAddr/PrWD       CPU byte address and write data
//   PrRD/PrReady/PrErr  read data, done pulse, error qualifier (valid with PrReady)
//   DevSel/DevWr      one-hot device select / write enable, ACCESS state only
//   DevAddr/DevWD     latched offset within the device window and write data
//   DevRD/DevReady    per-device read data (device i at [32*i+31:32*i]) and ready
module sys_bridge_hs #(
  parameter int unsigned DEV_COUNT   = 3,
  parameter int unsigned DEV_ADDR_WD = 4,
  parameter int unsigned DEV_ID_WD   = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_7F00,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      PrReq,
  input  logic                      PrWen,
  input  logic [31:0]               PrAddr,
  input  logic [31:0]               PrWD,
  output logic [31:0]               PrRD,
  output logic                      PrReady,
  output logic                      PrErr,
  output logic [DEV_COUNT-1:0]      DevSel,
  output logic [DEV_COUNT-1:0]      DevWr,
  output logic [DEV_ADDR_WD-1:0]    DevAddr,
  output logic [31:0]               DevWD,
  input  logic [32*DEV_COUNT-1:0]   DevRD,
  input  logic [DEV_COUNT-1:0]      DevReady
);

  localparam int unsigned RegionLsb = DEV_ADDR_WD + DEV_ID_WD;
  localparam int unsigned CntWd     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntWd-1:0] CntLast = CntWd'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } stateT;

  stateT                  stateQ, stateD;
  logic                   wenQ;
  logic [DEV_ID_WD-1:0]   idQ;
  logic [DEV_ADDR_WD-1:0] devAddrQ;
  logic [31:0]            devWdQ;
  logic [CntWd-1:0]       cntQ, cntD;
  logic                   errQ, errD;
  logic [31:0]            prRdQ, prRdD;

  // Request decode, evaluated on the live CPU bus while idle.
  logic [DEV_ID_WD-1:0]   reqId;
  logic                   inRegion;
  logic                   idValid;

  assign reqId    = PrAddr[RegionLsb-1:DEV_ADDR_WD];
  assign inRegion = (PrAddr >> RegionLsb) == (BASE_ADDR >> RegionLsb);
  assign idValid  = {{(32 - DEV_ID_WD){1'b0}}, reqId} < DEV_COUNT;

  // Ready and read data of the latched target only; other devices are ignored.
  logic        selReady;
  logic [31:0] selRd;

  always_comb begin
    selReady = 1'b0;
    selRd    = '0;
    for (int i = 0; i < int'(DEV_COUNT); i++) begin
      if (idQ == DEV_ID_WD'(i)) begin
        selReady = DevReady[i];
        selRd    = DevRD[32*i +: 32];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    errD   = errQ;
    prRdD  = prRdQ;
    unique case (stateQ)
      StIdle: begin
        if (PrReq) begin
          cntD = '0;
          if (inRegion && idValid) begin
            stateD = StAccess;
            errD   = 1'b0;
          end else begin
            // Decode error: skip the device entirely and answer next cycle.
            stateD = StDone;
            errD   = 1'b1;
            prRdD  = '0;
          end
        end
      end
      StAccess: begin
        if (selReady) begin
          stateD = StDone;
          errD   = 1'b0;
          prRdD  = wenQ ? 32'h0 : selRd;
        end else if (cntQ == CntLast) begin
          stateD = StDone;
          errD   = 1'b1;
          prRdD  = '0;
        end else begin
          cntD = cntQ + CntWd'(1);
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= StIdle;
      wenQ     <= 1'b0;
      idQ      <= '0;
      devAddrQ <= '0;
      devWdQ   <= '0;
      cntQ     <= '0;
      errQ     <= 1'b0;
      prRdQ    <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      errQ   <= errD;
      prRdQ  <= prRdD;
      // Capture the access only when it is accepted; PrReq is ignored elsewhere.
      if (stateQ == StIdle && PrReq) begin
        wenQ     <= PrWen;
        idQ      <= reqId;
        devAddrQ <= PrAddr[DEV_ADDR_WD-1:0];
        devWdQ   <= PrWD;
      end
    end
  end

  // Device-side outputs are decoded from state so they drop as soon as ACCESS
  // is left (completion, timeout or reset).
  always_comb begin
    DevSel = '0;
    for (int i = 0; i < int'(DEV_COUNT); i++) begin
      DevSel[i] = (stateQ == StAccess) && (idQ == DEV_ID_WD'(i));
    end
  end

  assign DevWr   = DevSel & {DEV_COUNT{wenQ}};
  assign DevAddr = devAddrQ;
  assign DevWD   = devWdQ;

  assign PrReady = (stateQ == StDone);
  assign PrErr   = errQ;
  assign PrRD    = prRdQ;

  // At most one device is ever selected, and writes only go to the selected one.
  assert property (@(posedge clk) disable iff (reset) $onehot0(DevSel));
  assert property (@(posedge clk) disable iff (reset) (DevWr & ~DevSel) == '0);

endmodule

// File: tb/tb_sys_bridge_hs.sv
// Bench for sys_bridge_hs: directed accesses with a timeline model. Each issued
// access is turned into per-cycle expectations (select window, done cycle, read
// data, error) that a negedge compare process checks every cycle.
module tb_sys_bridge_hs;

  localparam int NCyc    = 4096;
  localparam int Timeout = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        PrReq, PrWen;
  logic [31:0] PrAddr, PrWD;
  logic [31:0] PrRD;
  logic        PrReady, PrErr;
  logic [2:0]  DevSel, DevWr;
  logic [3:0]  DevAddr;
  logic [31:0] DevWD;
  logic [95:0] DevRD;
  logic [2:0]  DevReady;

  sys_bridge_hs #(
    .DEV_COUNT  (3),
    .DEV_ADDR_WD(4),
    .DEV_ID_WD  (2),
    .BASE_ADDR  (32'h0000_7F00),
    .TIMEOUT    (Timeout)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .PrReq   (PrReq),
    .PrWen   (PrWen),
    .PrAddr  (PrAddr),
    .PrWD    (PrWD),
    .PrRD    (PrRD),
    .PrReady (PrReady),
    .PrErr   (PrErr),
    .DevSel  (DevSel),
    .DevWr   (DevWr),
    .DevAddr (DevAddr),
    .DevWD   (DevWD),
    .DevRD   (DevRD),
    .DevReady(DevReady)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nPass  = 0;
  int nTotal = 0;
  bit chkOn  = 1'b0;

  // Per-cycle expectations produced by the model.
  bit [2:0]  expSel   [NCyc];
  bit [2:0]  expWr    [NCyc];
  bit [3:0]  expAddr  [NCyc];
  bit [31:0] expWd    [NCyc];
  bit        expReady [NCyc];
  bit        expErr   [NCyc];
  bit [31:0] expRd    [NCyc];
  bit        rdZero   [NCyc];
  logic [31:0] heldRd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (chkOn && cyc < NCyc) begin
      if (rdZero[cyc]) heldRd = 32'h0;
      if (expReady[cyc]) heldRd = expRd[cyc];
      chk("DevSel", {29'h0, DevSel}, {29'h0, expSel[cyc]});
      chk("DevWr", {29'h0, DevWr}, {29'h0, expWr[cyc]});
      chk("PrReady", {31'h0, PrReady}, {31'h0, expReady[cyc]});
      chk("PrRD", PrRD, heldRd);
      if (expSel[cyc] != 3'b000) begin
        chk("DevAddr", {28'h0, DevAddr}, {28'h0, expAddr[cyc]});
        chk("DevWD", DevWD, expWd[cyc]);
      end
      if (expReady[cyc]) chk("PrErr", {31'h0, PrErr}, {31'h0, expErr[cyc]});
    end
  end

  // Issue one access. waitCyc: ACCESS cycle index in which the target raises
  // DevReady (past the budget means never in time). rstAt >= 0 asserts reset in
  // that ACCESS cycle index.
  task automatic doAccess(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                          input int waitCyc, input logic [31:0] rdVal, input logic [2:0] noise,
                          input int rstAt, output int lat, output int selCnt,
                          output logic [31:0] rdSeen, output logic errSeen);
    logic [31:0] base;
    logic [2:0]  oneHot;
    int          t, k, nSel, id;
    bit          ok, success, finished;
    base    = 32'h0000_7F00;
    id      = int'(addr[5:4]);
    ok      = (addr[31:6] == base[31:6]) && (id < 3);
    oneHot  = 3'(1 << id);
    t       = cyc + 1;
    success = ok && waitCyc >= 0 && waitCyc <= Timeout - 1;
    k       = !ok ? 0 : (success ? waitCyc + 1 : Timeout);
    nSel    = k;
    if (rstAt >= 0 && rstAt + 1 < nSel) nSel = rstAt + 1;
    for (int c = 0; c < nSel; c++) begin
      expSel[t+c]  = oneHot;
      expWr[t+c]   = wen ? oneHot : 3'b000;
      expAddr[t+c] = addr[3:0];
      expWd[t+c]   = wd;
    end
    if (rstAt < 0 || rstAt >= k) begin
      expReady[t+k] = 1'b1;
      expErr[t+k]   = !success;
      expRd[t+k]    = (success && !wen) ? rdVal : 32'h0;
    end
    if (rstAt >= 0) rdZero[t+rstAt+1] = 1'b1;

    PrReq = 1'b1; PrWen = wen; PrAddr = addr; PrWD = wd;
    lat = -1; selCnt = 0; rdSeen = 32'h0; errSeen = 1'b0; finished = 1'b0;
    for (int i = 0; i < 40 && !finished; i++) begin
      @(posedge clk); #1;
      reset = (rstAt >= 0 && i == rstAt);
      if (reset) PrReq = 1'b0;
      DevReady = (noise & ~oneHot) | ((i == waitCyc) ? oneHot : 3'b000);
      for (int d = 0; d < 3; d++)
        DevRD[32*d +: 32] = (d == id) ? rdVal : (rdVal ^ 32'hFFFF_0000 ^ 32'(d));
      @(negedge clk);
      if (DevSel != 3'b000) selCnt++;
      if (PrReady) begin
        lat = i + 1; rdSeen = PrRD; errSeen = PrErr; finished = 1'b1;
      end
      if (rstAt >= 0 && i == rstAt + 1) finished = 1'b1;
    end
    @(posedge clk); #1;
    PrReq = 1'b0; DevReady = 3'b000; reset = 1'b0;
  endtask

  int          lat, selCnt;
  logic [31:0] rd;
  logic        err;

  initial begin
    reset = 1'b1; PrReq = 1'b0; PrWen = 1'b0; PrAddr = 32'h0; PrWD = 32'h0;
    DevRD = '0; DevReady = 3'b000;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0; chkOn = 1'b1;
    @(negedge clk);
    chk("rstPrRD", PrRD, 32'h0);
    chk("rstPrReady", {31'h0, PrReady}, 32'h0);
    chk("rstDevSel", {29'h0, DevSel}, 32'h0);
    @(posedge clk); #1;

    // 1: zero-wait read of device 1
    doAccess(1'b0, 32'h7F14, 32'h0, 0, 32'hCAFE_0001, 3'b000, -1, lat, selCnt, rd, err);
    chk("t1Lat", 32'(lat), 32'd2);
    chk("t1Rd", rd, 32'hCAFE_0001);
    chk("t1Err", {31'h0, err}, 32'h0);
    chk("t1Sel", 32'(selCnt), 32'd1);

    // 2: write to device 0 with three wait cycles; other devices' ready ignored
    doAccess(1'b1, 32'h7F08, 32'h1234_5678, 3, 32'h5555_AAAA, 3'b110, -1, lat, selCnt, rd, err);
    chk("t2Lat", 32'(lat), 32'd5);
    chk("t2Rd", rd, 32'h0);
    chk("t2Err", {31'h0, err}, 32'h0);
    chk("t2Sel", 32'(selCnt), 32'd4);

    // read device 2 so that the following decode error must clear PrRD
    doAccess(1'b0, 32'h7F2C, 32'h0, 1, 32'hA5A5_5A5A, 3'b001, -1, lat, selCnt, rd, err);
    chk("t2bLat", 32'(lat), 32'd3);
    chk("t2bRd", rd, 32'hA5A5_5A5A);

    // 3: unmapped device id 3
    doAccess(1'b0, 32'h7F30, 32'h0, 0, 32'h1111_1111, 3'b000, -1, lat, selCnt, rd, err);
    chk("t3Lat", 32'(lat), 32'd1);
    chk("t3Err", {31'h0, err}, 32'h1);
    chk("t3Rd", rd, 32'h0);
    chk("t3Sel", 32'(selCnt), 32'd0);

    // 4: outside the region
    doAccess(1'b0, 32'h0000_1F00, 32'h0, 0, 32'h2222_2222, 3'b000, -1, lat, selCnt, rd, err);
    chk("t4Lat", 32'(lat), 32'd1);
    chk("t4Err", {31'h0, err}, 32'h1);
    chk("t4Sel", 32'(selCnt), 32'd0);

    // 5: device 2 never ready in time; its late ready lands in DONE
    doAccess(1'b0, 32'h7F20, 32'h0, 15, 32'h3333_3333, 3'b011, -1, lat, selCnt, rd, err);
    chk("t5Lat", 32'(lat), 32'd16);
    chk("t5Sel", 32'(selCnt), 32'd15);
    chk("t5Err", {31'h0, err}, 32'h1);
    chk("t5Rd", rd, 32'h0);

    // ready on the last budgeted cycle still succeeds
    doAccess(1'b0, 32'h7F1C, 32'h0, 14, 32'h1357_9BDF, 3'b000, -1, lat, selCnt, rd, err);
    chk("t5bLat", 32'(lat), 32'd16);
    chk("t5bErr", {31'h0, err}, 32'h0);
    chk("t5bRd", rd, 32'h1357_9BDF);

    // 6: reset in the second ACCESS cycle of a device-0 write
    doAccess(1'b1, 32'h7F04, 32'hDEAD_BEEF, 5, 32'h0, 3'b000, 1, lat, selCnt, rd, err);
    chk("t6NoReady", 32'(lat), 32'hFFFF_FFFF);
    chk("t6Sel", 32'(selCnt), 32'd2);
    chk("t6PrRD", PrRD, 32'h0);
    doAccess(1'b0, 32'h7F18, 32'h0, 1, 32'h0BAD_F00D, 3'b100, -1, lat, selCnt, rd, err);
    chk("t6bLat", 32'(lat), 32'd3);
    chk("t6bRd", rd, 32'h0BAD_F00D);
    chk("t6bErr", {31'h0, err}, 32'h0);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chkOn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
